// File: rtl/ecc_dec_16to11_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ecc_dec_16to11_pipe
// Brief    : Two-stage SECDED decoder for 11-bit data / 16-bit Hamming codewords,
//            with saturating CE/UE counters and first-UE codeword capture.
// Revision : 1.0
// ============================================================================
module ecc_dec_16to11_pipe #(
    parameter int               CNT_W     = 16,
    parameter logic [CNT_W-1:0] CE_THRESH = CNT_W'(8)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [10:0]      out_data,
    output logic             out_correct,
    output logic             out_uncorrect,
    output logic [3:0]       out_location,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_ce,
    output logic [CNT_W-1:0] cnt_ue,
    output logic             ce_alarm,
    output logic             ue_log_valid,
    output logic [15:0]      ue_log_code
);

    logic             r_s1_valid;
    logic [15:0]      r_s1_code;
    logic [3:0]       r_s1_syn;
    logic             r_s1_par;
    logic [15:0]      r_s2_code;

    logic             w_s1_advance;
    logic             w_in_fire;
    logic             w_out_fire;
    logic [3:0]       w_syn;
    logic             w_par;
    logic [15:0]      w_fixed;
    logic [10:0]      w_data;
    logic             w_corr;
    logic             w_unc;
    logic [3:0]       w_loc;

    // Stage 2 may refill whenever the output register is empty or draining.
    assign w_s1_advance = !out_valid || out_ready;
    assign in_ready     = !r_s1_valid || w_s1_advance;
    assign w_in_fire    = in_valid && in_ready;
    assign w_out_fire   = out_valid && out_ready;

    always_comb begin
        w_syn = 4'd0;
        for (int i = 1; i < 16; i++) begin
            if (in_code[i]) begin
                w_syn = w_syn ^ 4'(i);
            end
        end
    end

    assign w_par = ^in_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_code  <= 16'd0;
            r_s1_syn   <= 4'd0;
            r_s1_par   <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (w_in_fire) begin
                r_s1_code <= in_code;
                r_s1_syn  <= w_syn;
                r_s1_par  <= w_par;
            end
        end
    end

    // Odd overall parity means a single flip at the syndrome position (0 = parity bit).
    always_comb begin
        w_fixed = r_s1_code;
        if (r_s1_par) begin
            w_fixed[r_s1_syn] = ~r_s1_code[r_s1_syn];
        end
    end

    assign w_data = {w_fixed[15:9], w_fixed[7:5], w_fixed[3]};
    assign w_corr = r_s1_par;
    assign w_unc  = !r_s1_par && (r_s1_syn != 4'd0);
    assign w_loc  = r_s1_par ? r_s1_syn : 4'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_data      <= 11'd0;
            out_correct   <= 1'b0;
            out_uncorrect <= 1'b0;
            out_location  <= 4'd0;
            r_s2_code     <= 16'd0;
        end else if (w_s1_advance) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_data      <= w_data;
                out_correct   <= w_corr;
                out_uncorrect <= w_unc;
                out_location  <= w_loc;
                r_s2_code     <= r_s1_code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_ce       <= '0;
            cnt_ue       <= '0;
            ue_log_valid <= 1'b0;
            ue_log_code  <= 16'd0;
        end else if (clr_cnt) begin
            cnt_ce       <= '0;
            cnt_ue       <= '0;
            ue_log_valid <= 1'b0;
            ue_log_code  <= 16'd0;
        end else if (w_out_fire) begin
            if (out_correct && (cnt_ce != '1)) begin
                cnt_ce <= cnt_ce + CNT_W'(1);
            end
            if (out_uncorrect && (cnt_ue != '1)) begin
                cnt_ue <= cnt_ue + CNT_W'(1);
            end
            if (out_uncorrect && !ue_log_valid) begin
                ue_log_valid <= 1'b1;
                ue_log_code  <= r_s2_code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_alarm <= 1'b0;
        end else begin
            ce_alarm <= (cnt_ce >= CE_THRESH);
        end
    end

endmodule
`default_nettype wire
